// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter that serialises register-bus transactions from several
// masters onto one shared bus. A transaction is latched at grant, held on the
// bus while the target stalls, and aborted with an error if the stall lasts
// too long, so a hung target cannot lock out the other masters.
module bus_master_arbiter #(
  parameter int num_masters    = 2,
  parameter int address_width  = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 1024,
  localparam int owner_width   = (num_masters > 1) ? $clog2(num_masters) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_masters-1:0]              req_i,
  input  logic [num_masters-1:0]              we_i,
  input  logic [num_masters*address_width-1:0] address_i,
  input  logic [num_masters*data_width-1:0]   data_i,
  output logic [num_masters-1:0]              ack_o,
  output logic [num_masters-1:0]              err_o,
  output logic [data_width-1:0]               rdata_o,
  output logic                                busy_o,
  output logic [owner_width-1:0]              owner_o,
  output logic                                bus_we_o,
  output logic [address_width-1:0]           bus_address_o,
  output logic [data_width-1:0]               bus_data_o,
  input  logic [data_width-1:0]               bus_data_i,
  input  logic                                bus_halt_i
);

  localparam int cnt_width = $clog2(timeout_cycles + 1);

  localparam logic [1:0] state_idle  = 2'd0;
  localparam logic [1:0] state_issue = 2'd1;
  localparam logic [1:0] state_ack   = 2'd2;

  logic [1:0]             state;
  logic [owner_width-1:0] last_owner;
  logic                   we_q;
  logic                   err_q;
  logic [cnt_width-1:0]   stall_cnt;

  logic                     grant_valid;
  logic [owner_width-1:0]   grant_idx;
  logic                     hi_valid;
  logic [owner_width-1:0]   hi_idx;
  logic [owner_width-1:0]   lo_idx;
  logic                     grant_we;
  logic [address_width-1:0] grant_addr;
  logic [data_width-1:0]    grant_data;

  // Round-robin pick: lowest requester above last_owner, else lowest overall.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    hi_valid    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int j = num_masters - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        grant_valid = 1'b1;
        lo_idx      = owner_width'(j);
        if (j > int'(last_owner)) begin
          hi_valid = 1'b1;
          hi_idx   = owner_width'(j);
        end
      end
    end
    grant_idx = hi_valid ? hi_idx : lo_idx;
  end

  // Payload multiplexer for the master being granted this cycle.
  always_comb begin
    grant_we   = 1'b0;
    grant_addr = '0;
    grant_data = '0;
    for (int j = 0; j < num_masters; j++) begin
      if (owner_width'(j) == grant_idx) begin
        grant_we   = we_i[j];
        grant_addr = address_i[j*address_width +: address_width];
        grant_data = data_i[j*data_width +: data_width];
      end
    end
  end

  // Transaction FSM: grant in IDLE, hold the bus in ISSUE, pulse in ACK.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so they all update together at the edge.
    if (reset_i) begin
      state         <= state_idle;
      owner_o       <= '0;
      last_owner    <= owner_width'(num_masters - 1);
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      stall_cnt     <= '0;
      bus_address_o <= '0;
      bus_data_o    <= '0;
      rdata_o       <= '0;
    end else begin
      case (state)
        state_idle: begin
          if (grant_valid) begin
            state         <= state_issue;
            owner_o       <= grant_idx;
            we_q          <= grant_we;
            bus_address_o <= grant_addr;
            bus_data_o    <= grant_data;
            stall_cnt     <= '0;
          end
        end
        state_issue: begin
          if (!bus_halt_i) begin
            if (!we_q) rdata_o <= bus_data_i;
            stall_cnt <= '0;
            state     <= state_ack;
          end else if (stall_cnt == cnt_width'(timeout_cycles)) begin
            // Target never released halt: abort with all-ones read data.
            err_q     <= 1'b1;
            rdata_o   <= '1;
            stall_cnt <= '0;
            state     <= state_ack;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        state_ack: begin
          last_owner <= owner_o;
          err_q      <= 1'b0;
          state      <= state_idle;
        end
        default: state <= state_idle;
      endcase
    end
  end

  // Status and strobes decoded from the FSM state.
  always_comb begin
    busy_o   = (state == state_issue) || (state == state_ack);
    bus_we_o = (state == state_issue) && we_q;
    ack_o    = '0;
    err_o    = '0;
    if (state == state_ack) begin
      ack_o = num_masters'(1) << owner_o;
      if (err_q) err_o = num_masters'(1) << owner_o;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter with two masters and a short timeout.
// A cycle table covers reset, single write, stalled read with owner dropping
// req and changing address, and round-robin; hand sequences cover timeout
// abort and reset in the middle of a stalled transaction.
module tb_bus_master_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [31:0] a0, a1, d0, d1;
  logic [1:0]  ack_o, err_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic [0:0]  owner_o;
  logic        bus_we_o;
  logic [31:0] bus_address_o, bus_data_o, bus_data_i;
  logic        bus_halt_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bus_master_arbiter #(
    .num_masters(2), .address_width(32), .data_width(32), .timeout_cycles(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
    .address_i({a1, a0}), .data_i({d1, d0}),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .owner_o(owner_o), .bus_we_o(bus_we_o), .bus_address_o(bus_address_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_halt_i(bus_halt_i)
  );

  typedef struct {
    logic rst; logic [1:0] req; logic [1:0] we; logic halt; logic [31:0] bd;
    logic [31:0] a0; logic [31:0] a1; logic [31:0] d0; logic [31:0] d1;
    logic [1:0] e_ack; logic [1:0] e_err; logic e_busy; logic e_owner; logic e_bwe;
    logic [31:0] e_addr; logic [31:0] e_wdata; logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] we,
                              input logic halt, input logic [31:0] bd,
                              input logic [31:0] xa0, input logic [31:0] xa1,
                              input logic [31:0] xd0, input logic [31:0] xd1,
                              input logic [1:0] e_ack, input logic [1:0] e_err,
                              input logic e_busy, input logic e_owner, input logic e_bwe,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.halt = halt; v.bd = bd;
    v.a0 = xa0; v.a1 = xa1; v.d0 = xd0; v.d1 = xd1;
    v.e_ack = e_ack; v.e_err = e_err; v.e_busy = e_busy; v.e_owner = e_owner;
    v.e_bwe = e_bwe; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; req_i = '0; we_i = '0; bus_halt_i = 1'b0; bus_data_i = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;

    // Row r: inputs sampled at edge r, expected outputs in the cycle after it.
    //                 rst req we  h  bd            a0            a1            d0            d1            ack err bsy own bwe addr          wdata         rdata
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0));
    // single write, master 0, no stall
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        32'h9000_0010, 32'h0,       32'hA5A5_0001, 32'h0,       0,  0,  1,  0,  1,  32'h9000_0010, 32'hA5A5_0001, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        32'h9000_0010, 32'h0,       32'hA5A5_0001, 32'h0,       1,  0,  1,  0,  0,  32'h9000_0010, 32'hA5A5_0001, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h9000_0010, 32'h0,       32'hA5A5_0001, 32'h0,       0,  0,  0,  0,  0,  32'h9000_0010, 32'hA5A5_0001, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h9000_0010, 32'h0,       32'hA5A5_0001, 32'h0,       0,  0,  0,  0,  0,  32'h9000_0010, 32'hA5A5_0001, 32'h0));
    // read by master 1, halt high for 5 ISSUE cycles; req dropped and address changed mid-stall
    vecs.push_back(mk(0, 2, 0, 1, 32'hDEAD_BEEF, 32'h9000_0010, 32'h9000_0004, 32'hA5A5_0001, 32'h5555_0000, 0, 0, 1, 1, 0, 32'h9000_0004, 32'h5555_0000, 32'h0));
    vecs.push_back(mk(0, 2, 0, 1, 32'hDEAD_BEEF, 32'h9000_0010, 32'h9000_0004, 32'hA5A5_0001, 32'h5555_0000, 0, 0, 1, 1, 0, 32'h9000_0004, 32'h5555_0000, 32'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h9000_0010, 32'h1111_1111, 32'hA5A5_0001, 32'h5555_0000, 0, 0, 1, 1, 0, 32'h9000_0004, 32'h5555_0000, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h1234_5678, 32'h9000_0010, 32'h1111_1111, 32'hA5A5_0001, 32'h5555_0000, 2, 0, 1, 1, 0, 32'h9000_0004, 32'h5555_0000, 32'h1234_5678));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h9000_0010, 32'h1111_1111, 32'hA5A5_0001, 32'h5555_0000, 0, 0, 0, 1, 0, 32'h9000_0004, 32'h5555_0000, 32'h1234_5678));
    // both masters request writes continuously: grants alternate 0,1,0
    for (int g = 0; g < 3; g++) begin
      logic        o;
      logic [31:0] ea, ed;
      o  = g[0];
      ea = o ? 32'hA1 : 32'hA0;
      ed = o ? 32'hD1 : 32'hD0;
      vecs.push_back(mk(0, 3, 3, 0, 32'h0, 32'hA0, 32'hA1, 32'hD0, 32'hD1, 0, 0, 1, o, 1, ea, ed, 32'h1234_5678));
      vecs.push_back(mk(0, 3, 3, 0, 32'h0, 32'hA0, 32'hA1, 32'hD0, 32'hD1, o ? 2'd2 : 2'd1, 0, 1, o, 0, ea, ed, 32'h1234_5678));
      vecs.push_back(mk(0, 3, 3, 0, 32'h0, 32'hA0, 32'hA1, 32'hD0, 32'hD1, 0, 0, 0, o, 0, ea, ed, 32'h1234_5678));
    end

    foreach (vecs[i]) begin
      reset_i = vecs[i].rst; req_i = vecs[i].req; we_i = vecs[i].we;
      bus_halt_i = vecs[i].halt; bus_data_i = vecs[i].bd;
      a0 = vecs[i].a0; a1 = vecs[i].a1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      tick();
      check($sformatf("row%0d ack", i),   32'(ack_o),         32'(vecs[i].e_ack));
      check($sformatf("row%0d err", i),   32'(err_o),         32'(vecs[i].e_err));
      check($sformatf("row%0d busy", i),  32'(busy_o),        32'(vecs[i].e_busy));
      check($sformatf("row%0d owner", i), 32'(owner_o),       32'(vecs[i].e_owner));
      check($sformatf("row%0d bus_we", i), 32'(bus_we_o),     32'(vecs[i].e_bwe));
      check($sformatf("row%0d bus_addr", i), bus_address_o,   vecs[i].e_addr);
      check($sformatf("row%0d bus_data", i), bus_data_o,      vecs[i].e_wdata);
      check($sformatf("row%0d rdata", i), rdata_o,            vecs[i].e_rdata);
    end

    // Timeout: master 1 (next in turn) reads with halt stuck high; master 0 queued.
    req_i = 2'b11; we_i = 2'b00; a0 = 32'hB0; a1 = 32'hB1; bus_halt_i = 1'b1;
    tick();
    check("timeout grant owner", 32'(owner_o), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("timeout wait%0d ack", k), 32'(ack_o), 32'd0);
      check($sformatf("timeout wait%0d addr", k), bus_address_o, 32'hB1);
    end
    tick();
    check("timeout ack", 32'(ack_o), 32'b10);
    check("timeout err", 32'(err_o), 32'b10);
    check("timeout rdata", rdata_o, 32'hFFFF_FFFF);
    req_i = 2'b01; bus_halt_i = 1'b0; bus_data_i = 32'hCAFE_0000;
    tick();
    check("post-timeout idle ack", 32'(ack_o), 32'd0);
    check("post-timeout idle err", 32'(err_o), 32'd0);
    tick();
    check("queued grant owner", 32'(owner_o), 32'd0);
    check("queued grant addr", bus_address_o, 32'hB0);
    tick();
    check("queued ack", 32'(ack_o), 32'b01);
    check("queued err", 32'(err_o), 32'd0);
    check("queued rdata", rdata_o, 32'hCAFE_0000);
    req_i = 2'b00;
    tick();

    // Reset while master 1 has a stalled write on the bus.
    req_i = 2'b10; we_i = 2'b10; a1 = 32'hC1; d1 = 32'hC1C1; bus_halt_i = 1'b1;
    tick();
    check("stalled write owner", 32'(owner_o), 32'd1);
    check("stalled write we", 32'(bus_we_o), 32'd1);
    tick();
    reset_i = 1'b1;
    tick();
    check("reset ack", 32'(ack_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset bus_we", 32'(bus_we_o), 32'd0);
    check("reset owner", 32'(owner_o), 32'd0);
    check("reset bus_addr", bus_address_o, 32'd0);
    check("reset bus_data", bus_data_o, 32'd0);
    check("reset rdata", rdata_o, 32'd0);
    reset_i = 1'b0; req_i = 2'b11; we_i = 2'b00; bus_halt_i = 1'b0; bus_data_i = 32'h0BAD_F00D;
    tick();
    check("after reset grant addr", bus_address_o, 32'hB0);
    check("after reset grant owner", 32'(owner_o), 32'd0);
    tick();
    check("after reset ack", 32'(ack_o), 32'b01);
    check("after reset rdata", rdata_o, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
